conv_frame_ctrl: RTL and testbench

CONV_FRAME_CTRL -- requirements
Module: conv_frame_ctrl

---
 rtl/conv_frame_ctrl.sv | 158 +++++++++++++++
 tb/tb_conv_frame_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_frame_ctrl.sv
// Frame controller for a 3x3 convolution datapath: feeds pixels in raster order,
// captures interior results into a 2-deep output FIFO and signals frame completion.
module conv_frame_ctrl #(
  parameter int IMG_W = 502,
  parameter int IMG_H = 502
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        kernel_ld,
  input  logic [71:0] kernel_in,
  input  logic        pix_valid,
  input  logic [7:0]  pix_in,
  output logic        pix_ready,
  output logic        conv_clr,
  output logic        conv_we,
  output logic [7:0]  conv_din,
  output logic [71:0] conv_kernel,
  input  logic [7:0]  conv_dout,
  output logic        out_valid,
  output logic [7:0]  out_data,
  input  logic        out_ready,
  output logic        busy,
  output logic        done
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLR,
    S_RUN,
    S_FLUSH
  } state_t;

  state_t        r_state;
  state_t        w_stateNext;
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic          r_capPend;
  logic [7:0]    r_mem [2];
  logic          r_wrPtr;
  logic          r_rdPtr;
  logic [1:0]    r_count;
  logic [71:0]   r_kernel;

  logic          w_pop;
  logic          w_push;
  logic [2:0]    w_occ;
  logic          w_fire;
  logic          w_capture;
  logic          w_lastPix;
  logic          w_drained;

  // Occupancy the FIFO will have after this cycle, counting a capture already in flight.
  assign w_pop     = (r_count != 2'd0) && out_ready;
  assign w_push    = r_capPend;
  assign w_occ     = {1'b0, r_count} + {2'b00, r_capPend} - {2'b00, w_pop};
  assign pix_ready = (r_state == S_RUN) && (w_occ <= 3'd1);
  assign w_fire    = pix_valid && pix_ready;
  assign w_capture = w_fire && (r_row >= ROW_TWO) && (r_col >= COL_TWO);
  assign w_lastPix = w_fire && (r_row == ROW_LAST) && (r_col == COL_LAST);
  assign w_drained = !r_capPend &&
                     ((r_count == 2'd0) || ((r_count == 2'd1) && w_pop));

  assign conv_clr    = (r_state == S_CLR);
  assign conv_we     = w_fire;
  assign conv_din    = w_fire ? pix_in : 8'd0;
  assign conv_kernel = r_kernel;
  assign out_valid   = (r_count != 2'd0);
  assign out_data    = r_mem[r_rdPtr];
  assign busy        = (r_state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    done        = 1'b0;
    case (r_state)
      S_IDLE:  if (start) w_stateNext = S_CLR;
      S_CLR:   w_stateNext = S_RUN;
      S_RUN:   if (w_lastPix) w_stateNext = S_FLUSH;
      S_FLUSH: begin
        if (w_drained) begin
          w_stateNext = S_IDLE;
          done        = 1'b1;
        end
      end
      default: w_stateNext = S_IDLE;
    endcase
  end

  // Kernel is only writable while idle so a running frame always sees one coefficient set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_kernel <= 72'd0;
    end else if ((r_state == S_IDLE) && kernel_ld) begin
      r_kernel <= kernel_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col     <= '0;
      r_row     <= '0;
      r_capPend <= 1'b0;
    end else begin
      r_capPend <= w_capture;
      if (r_state == S_CLR) begin
        r_col <= '0;
        r_row <= '0;
      end else if (w_fire) begin
        if (r_col == COL_LAST) begin
          r_col <= '0;
          r_row <= (r_row == ROW_LAST) ? '0 : r_row + RW'(1);
        end else begin
          r_col <= r_col + CW'(1);
        end
      end
    end
  end

  // The datapath output is valid one cycle after the shift, hence the push from r_capPend.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0] <= 8'd0;
      r_mem[1] <= 8'd0;
      r_wrPtr  <= 1'b0;
      r_rdPtr  <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wrPtr] <= conv_dout;
        r_wrPtr        <= ~r_wrPtr;
      end
      if (w_pop) begin
        r_rdPtr <= ~r_rdPtr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_frame_ctrl.sv
// Directed bench for conv_frame_ctrl on an 8x4 image with a behavioural 3x3 datapath stub;
// pixel value equals its raster index, so every interior result is predictable by hand.
module tb_conv_frame_ctrl;

  localparam int TB_W = 8;
  localparam int TB_H = 4;
  localparam int NPIX = TB_W * TB_H;
  localparam int NRES = (TB_W - 2) * (TB_H - 2);
  localparam int SRLEN = 2 * TB_W + 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        kernel_ld;
  logic [71:0] kernel_in;
  logic        pix_valid;
  logic [7:0]  pix_in;
  logic        pix_ready;
  logic        conv_clr;
  logic        conv_we;
  logic [7:0]  conv_din;
  logic [71:0] conv_kernel;
  logic [7:0]  conv_dout;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;
  logic        busy;
  logic        done;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  int cycleCnt = 0;
  int doneCount = 0;
  int doneCyc = 0;
  int clrCount = 0;
  int weCount = 0;
  logic [7:0] resQ [$];

  int pixIdx;
  int firstFireCyc;
  int lastFireCyc;
  int startCyc;

  localparam logic [71:0] KERNEL_ONE   = 72'h01 << 32;
  localparam logic [71:0] KERNEL_THREE = 72'h03 << 32;

  conv_frame_ctrl #(.IMG_W(TB_W), .IMG_H(TB_H)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .kernel_ld(kernel_ld),
    .kernel_in(kernel_in), .pix_valid(pix_valid), .pix_in(pix_in),
    .pix_ready(pix_ready), .conv_clr(conv_clr), .conv_we(conv_we),
    .conv_din(conv_din), .conv_kernel(conv_kernel), .conv_dout(conv_dout),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // Datapath stub: pixel line buffer, newest pixel in sr[0], k4 taps the window centre.
  logic [7:0] sr [SRLEN];
  always @(posedge clk) begin
    if (conv_clr) begin
      for (int i = 0; i < SRLEN; i++) sr[i] <= 8'd0;
    end else if (conv_we) begin
      sr[0] <= conv_din;
      for (int i = 1; i < SRLEN; i++) sr[i] <= sr[i-1];
    end
  end

  always_comb begin
    int acc;
    acc = 0;
    for (int i = 0; i < 9; i++)
      acc = acc + int'(conv_kernel[i*8 +: 8]) * int'(sr[(2 - i/3)*TB_W + (2 - i%3)]);
    conv_dout = 8'(acc);
  end

  // Observe handshakes mid-cycle so every popped result and pulse is recorded once.
  always @(negedge clk) begin
    if (out_valid && out_ready) resQ.push_back(out_data);
    if (done) begin
      doneCount <= doneCount + 1;
      doneCyc   <= cycleCnt;
    end
    if (conv_clr) clrCount <= clrCount + 1;
    if (conv_we)  weCount  <= weCount + 1;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout, required $finish");
    $fatal(1, "[TB] simulation did not terminate");
  end

  task automatic checkOutput(input string tag, input logic [71:0] observed,
                             input logic [71:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h required %0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Streams pixels until stopIdx have been accepted or the cycle budget runs out.
  task automatic applyStimulus(input int stopIdx, input int budget);
    int cyc;
    cyc = 0;
    while (pixIdx < stopIdx && cyc < budget) begin
      pix_valid = 1'b1;
      pix_in    = 8'(pixIdx);
      @(negedge clk);
      if (pix_ready) begin
        if (pixIdx == 0) firstFireCyc = cycleCnt;
        lastFireCyc = cycleCnt;
        pixIdx++;
      end
      step();
      cyc++;
    end
    pix_valid = 1'b0;
  endtask

  task automatic startFrame(input logic [71:0] k, input logic ld);
    start     = 1'b1;
    kernel_ld = ld;
    kernel_in = k;
    startCyc  = cycleCnt;
    pixIdx    = 0;
    step();
    start     = 1'b0;
    kernel_ld = 1'b0;
    kernel_in = 72'd0;
  endtask

  task automatic checkResults(input string tag, input int base, input int mult);
    int n;
    int r;
    int c;
    n = resQ.size() - base;
    checkOutput({tag, "_count"}, 72'(n), 72'(NRES));
    for (int i = 0; i < NRES && i < n; i++) begin
      r = 2 + i / (TB_W - 2);
      c = 2 + i % (TB_W - 2);
      checkOutput({tag, "_res"}, 72'(resQ[base + i]),
                  72'(8'(mult * ((r - 1) * TB_W + (c - 1)))));
    end
  endtask

  int resBase;
  int doneBase;
  int clrBase;
  int weBase;

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    kernel_ld = 1'b0;
    kernel_in = 72'hFF_FFFF_FFFF_FFFF_FFFF;
    pix_valid = 1'b1;
    pix_in    = 8'hA5;
    out_ready = 1'b1;
    pixIdx    = 0;

    #2;
    checkOutput("rst_pix_ready", 72'(pix_ready), 72'd0);
    checkOutput("rst_conv_clr", 72'(conv_clr), 72'd0);
    checkOutput("rst_conv_we", 72'(conv_we), 72'd0);
    checkOutput("rst_conv_din", 72'(conv_din), 72'd0);
    checkOutput("rst_conv_kernel", conv_kernel, 72'd0);
    checkOutput("rst_out_valid", 72'(out_valid), 72'd0);
    checkOutput("rst_out_data", 72'(out_data), 72'd0);
    checkOutput("rst_busy", 72'(busy), 72'd0);
    checkOutput("rst_done", 72'(done), 72'd0);
    step();
    step();
    pix_valid = 1'b0;
    kernel_in = 72'd0;
    rst_n = 1'b1;
    step();
    checkOutput("idle_out_valid", 72'(out_valid), 72'd0);

    $display("[TB] frame A: centre tap, coincident load and start, full throughput");
    resBase = resQ.size(); doneBase = doneCount; clrBase = clrCount; weBase = weCount;
    startFrame(KERNEL_ONE, 1'b1);
    checkOutput("A_kernel", conv_kernel, KERNEL_ONE);
    checkOutput("A_busy", 72'(busy), 72'd1);
    applyStimulus(NPIX, 300);
    repeat (6) step();
    checkOutput("A_pix_sent", 72'(pixIdx), 72'(NPIX));
    checkOutput("A_first_fire", 72'(firstFireCyc - startCyc), 72'd2);
    checkOutput("A_no_gaps", 72'(lastFireCyc - firstFireCyc), 72'(NPIX - 1));
    checkOutput("A_we_count", 72'(weCount - weBase), 72'(NPIX));
    checkOutput("A_clr_count", 72'(clrCount - clrBase), 72'd1);
    checkOutput("A_done_count", 72'(doneCount - doneBase), 72'd1);
    checkOutput("A_done_latency", 72'(doneCyc - lastFireCyc), 72'd2);
    checkOutput("A_busy_end", 72'(busy), 72'd0);
    checkOutput("A_out_valid_end", 72'(out_valid), 72'd0);
    checkResults("A", resBase, 1);

    $display("[TB] frame B: separate kernel load, backpressure");
    kernel_ld = 1'b1;
    kernel_in = KERNEL_THREE;
    step();
    kernel_ld = 1'b0;
    kernel_in = 72'd0;
    checkOutput("B_kernel", conv_kernel, KERNEL_THREE);
    checkOutput("B_ld_no_start", 72'(busy), 72'd0);
    resBase = resQ.size(); doneBase = doneCount;
    out_ready = 1'b0;
    startFrame(72'd0, 1'b0);
    applyStimulus(NPIX, 40);
    checkOutput("B_stall_idx", 72'(pixIdx), 72'd20);
    checkOutput("B_stall_ready", 72'(pix_ready), 72'd0);
    checkOutput("B_stall_valid", 72'(out_valid), 72'd1);
    checkOutput("B_stall_head", 72'(out_data), 72'd27);
    checkOutput("B_stall_none_out", 72'(resQ.size() - resBase), 72'd0);
    out_ready = 1'b1;
    applyStimulus(NPIX, 300);
    repeat (6) step();
    checkOutput("B_pix_sent", 72'(pixIdx), 72'(NPIX));
    checkOutput("B_done_count", 72'(doneCount - doneBase), 72'd1);
    checkResults("B", resBase, 3);

    $display("[TB] frame C: commands during RUN are ignored");
    resBase = resQ.size(); doneBase = doneCount; clrBase = clrCount;
    startFrame(72'd0, 1'b0);
    applyStimulus(10, 100);
    start     = 1'b1;
    kernel_ld = 1'b1;
    kernel_in = 72'hFF_FFFF_FFFF_FFFF_FFFF;
    step();
    start     = 1'b0;
    kernel_ld = 1'b0;
    kernel_in = 72'd0;
    step();
    checkOutput("C_kernel_kept", conv_kernel, KERNEL_THREE);
    checkOutput("C_busy", 72'(busy), 72'd1);
    checkOutput("C_still_run", 72'(pix_ready), 72'd1);
    checkOutput("C_no_reclear", 72'(clrCount - clrBase), 72'd1);
    applyStimulus(NPIX, 300);
    repeat (6) step();
    checkOutput("C_done_count", 72'(doneCount - doneBase), 72'd1);
    checkResults("C", resBase, 3);

    $display("[TB] frame D: abort at pixel 20, then restart");
    doneBase = doneCount;
    startFrame(KERNEL_ONE, 1'b1);
    applyStimulus(20, 100);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("D_abort_valid", 72'(out_valid), 72'd0);
    checkOutput("D_abort_busy", 72'(busy), 72'd0);
    checkOutput("D_abort_ready", 72'(pix_ready), 72'd0);
    checkOutput("D_abort_kernel", conv_kernel, 72'd0);
    checkOutput("D_abort_data", 72'(out_data), 72'd0);
    step();
    step();
    rst_n = 1'b1;
    step();
    checkOutput("D_abort_no_done", 72'(doneCount - doneBase), 72'd0);
    resBase = resQ.size(); doneBase = doneCount;
    startFrame(KERNEL_ONE, 1'b1);
    applyStimulus(NPIX, 300);
    repeat (6) step();
    checkOutput("D_pix_sent", 72'(pixIdx), 72'(NPIX));
    checkOutput("D_done_count", 72'(doneCount - doneBase), 72'd1);
    checkResults("D", resBase, 1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
